// File: rtl/fft_stream_pkg.sv
// fft_stream_pkg
//   Shared types and constants for the FFT result streamer.
//   - stream_state_e  : streamer FSM states (IDLE -> ISSUE -> DRAIN -> IDLE)
//   - FIFO_DEPTH_MARGIN / fifo_depth_legal() : legality of the output buffer
//     depth relative to the BRAM read latency.
package fft_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;

  // The buffer must absorb every read in flight (address flop plus BRAM
  // pipeline) plus the word currently presented on the stream.
  localparam int unsigned FIFO_DEPTH_MARGIN = 2;

  function automatic bit fifo_depth_legal(input int unsigned depth,
                                          input int unsigned rd_lat);
    return depth >= rd_lat + FIFO_DEPTH_MARGIN;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo
//   Synchronous FIFO with occupancy count. Push and pop in the same cycle are
//   both honoured, including when full (the pop frees the slot being written).
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_data    : write request and word
//   pop                : read request (ignored when empty)
//   pop_data           : word at the head of the queue (raw storage contents)
//   empty              : no words stored
//   count              : number of words stored, 0..DEPTH
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; the pointers and count are reset, so stale
  // contents are never observable and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fft_result_streamer.sv
// fft_result_streamer
//   Reads the N = 2**LOGN real FFT result words out of the shared FFT BRAM
//   and streams them in index order on a valid/ready interface.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : one-cycle request to stream all N words (IDLE only)
//   busy                 : streamer owns the BRAM (cycle after start .. done)
//   done                 : one-cycle pulse when the last word is accepted
//   rns_rd_addr          : registered BRAM read address
//   rns_rd_data          : BRAM read data, BRAM_RD_LAT cycles after address
//   m_data/m_valid/m_ready/m_last : output stream, m_last marks index N-1
module fft_result_streamer
  import fft_stream_pkg::*;
#(
  parameter int LOGN         = 13,
  parameter int FLP_WORDSIZE = 64,
  parameter int BRAM_RD_LAT  = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [LOGN-1:0]         rns_rd_addr,
  input  logic [FLP_WORDSIZE-1:0] rns_rd_data,
  output logic [FLP_WORDSIZE-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last
);

  localparam logic [LOGN-1:0] LAST_IDX = '1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // Wide enough for FIFO contents plus address flop plus BRAM pipeline.
  localparam int USE_W = $clog2(FIFO_DEPTH + BRAM_RD_LAT + 2);

  if (!fifo_depth_legal(FIFO_DEPTH, BRAM_RD_LAT)) begin : g_illegal_depth
    $error("fft_result_streamer: FIFO_DEPTH must be at least BRAM_RD_LAT+2");
  end

  stream_state_e            state_q, state_d;
  logic [LOGN-1:0]          idx_q, idx_d;
  logic                     issue;
  logic                     pop;
  logic                     credit_ok;
  logic                     rd_vld_q, rd_last_q;
  logic [BRAM_RD_LAT-1:0]   pipe_vld_q, pipe_last_q;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_empty;
  logic [FLP_WORDSIZE:0]    fifo_word;
  logic [USE_W-1:0]         used;

  assign pop = m_valid && m_ready;

  // Reads outstanding (address flop + BRAM pipeline) plus buffered words.
  // A word leaving this cycle frees its slot at the same edge, which keeps
  // one read per cycle flowing with FIFO_DEPTH = BRAM_RD_LAT+2.
  always_comb begin
    used = USE_W'(fifo_count) + USE_W'(rd_vld_q);
    for (int i = 0; i < BRAM_RD_LAT; i++) used = used + USE_W'(pipe_vld_q[i]);
    used = used - USE_W'(pop);
  end

  assign credit_ok = (used < USE_W'(FIFO_DEPTH));

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      // Index 0 is issued on the accepting edge so the first word reaches
      // m_valid BRAM_RD_LAT+2 cycles after start; the buffer is empty here.
      ST_IDLE: if (start) begin
        issue   = 1'b1;
        state_d = (idx_q == LAST_IDX) ? ST_DRAIN : ST_ISSUE;
      end
      ST_ISSUE: if (credit_ok) begin
        issue = 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (pop && m_last) begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Wraps to 0 after the last index, leaving IDLE ready for the next run.
    if (issue) idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rns_rd_addr <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      if (issue) rns_rd_addr <= idx_q;
      rd_vld_q  <= issue;
      rd_last_q <= issue && (idx_q == LAST_IDX);
      // Flags travel alongside the BRAM pipeline and emerge with the data.
      pipe_vld_q[0]  <= rd_vld_q;
      pipe_last_q[0] <= rd_last_q;
      for (int i = 1; i < BRAM_RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  stream_fifo #(
    .WIDTH (FLP_WORDSIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_vld_q[BRAM_RD_LAT-1]),
    .push_data ({pipe_last_q[BRAM_RD_LAT-1], rns_rd_data}),
    .pop       (pop),
    .pop_data  (fifo_word),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign busy    = (state_q != ST_IDLE);
  assign m_valid = !fifo_empty;
  // Gated so the stream reads as zero whenever nothing is presented.
  assign m_data  = m_valid ? fifo_word[FLP_WORDSIZE-1:0] : '0;
  assign m_last  = m_valid && fifo_word[FLP_WORDSIZE];

endmodule

// File: tb/tb_fft_result_streamer.sv
// tb_fft_result_streamer
//   Directed bench for fft_result_streamer with LOGN=4 (N=16), BRAM_RD_LAT=2,
//   FIFO_DEPTH=4 and BRAM contents mem[i] = 64'h1000 + i.
module tb_fft_result_streamer;

  localparam int LOGN  = 4;
  localparam int N     = 16;
  localparam int W     = 64;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int NV    = 22;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic         m_ready = 1'b0;
  logic         busy, done, m_valid, m_last;
  logic [LOGN-1:0] rns_rd_addr;
  logic [W-1:0] rns_rd_data, m_data;

  logic [W-1:0] mem [N];
  logic [W-1:0] bram_pipe [LAT];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         start;
    logic         ready;
    logic         exp_busy;
    logic         exp_done;
    logic         exp_valid;
    logic         exp_last;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  // BRAM model: registered read, data visible LAT cycles after the address.
  always @(posedge clk) begin
    bram_pipe[0] <= mem[rns_rd_addr];
    for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign rns_rd_data = bram_pipe[LAT-1];

  fft_result_streamer #(
    .LOGN         (LOGN),
    .FLP_WORDSIZE (W),
    .BRAM_RD_LAT  (LAT),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rns_rd_addr (rns_rd_addr),
    .rns_rd_data (rns_rd_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last)
  );

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams one run and checks order, m_last and the done pulse.
  // mode 0: ready high; 1: ready high, start re-pulsed at cycle 5;
  // mode 2: ready toggles 1/0; 3: ready low for 3 cycles on the last word.
  task automatic run_stream(input string tag, input bit do_start, input int mode);
    int got;
    int dones;
    int stall;
    int post;
    got = 0; dones = 0; stall = 0; post = 0;
    for (int c = 0; c < 200; c++) begin
      start = do_start && (c == 0 || (mode == 1 && c == 5));
      #1;
      if (mode == 2) m_ready = (c % 2 == 0);
      else if (mode == 3 && m_valid && got == N-1 && stall < 3) begin
        m_ready = 1'b0;
        stall++;
      end else m_ready = 1'b1;
      #1;
      if (mode == 3 && !m_ready) begin
        check({tag, "_stall_busy"}, busy, 1'b1);
        check({tag, "_stall_done"}, done, 1'b0);
      end
      if (done) dones++;
      if (m_valid && m_ready) begin
        check({tag, "_data"}, m_data, 64'h1000 + 64'(got));
        check({tag, "_last"}, m_last, got == N-1);
        if (got == N-1) check({tag, "_done"}, done, 1'b1);
        got++;
      end
      tick();
      if (got == N) post++;
      if (post > 2) break;
    end
    start = 1'b0;
    check({tag, "_words"}, got, N);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [127:0] act;
    logic [127:0] exp;
    int unstable;
    int bad;

    for (int i = 0; i < N; i++) mem[i] = 64'h1000 + 64'(i);

    // Plain streaming with m_ready high: first word at cycle 4, last at 19.
    for (int c = 0; c < NV; c++) begin
      vecs[c].start     = (c == 0);
      vecs[c].ready     = 1'b1;
      vecs[c].exp_busy  = (c >= 1 && c <= 19);
      vecs[c].exp_done  = (c == 19);
      vecs[c].exp_valid = (c >= 4 && c <= 19);
      vecs[c].exp_last  = (c == 19);
      vecs[c].exp_data  = (c >= 4 && c <= 19) ? 64'h1000 + 64'(c - 4) : 64'h0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  busy,        1'b0);
    check("rst_done",  done,        1'b0);
    check("rst_valid", m_valid,     1'b0);
    check("rst_last",  m_last,      1'b0);
    check("rst_data",  m_data,      64'h0);
    check("rst_addr",  rns_rd_addr, 4'h0);
    rst_n = 1'b1;
    tick();
    tick();

    for (int c = 0; c < NV; c++) begin
      start   = vecs[c].start;
      m_ready = vecs[c].ready;
      #1;
      act = {busy, done, m_valid, m_last,
             (vecs[c].exp_valid ? m_data : 64'h0)};
      exp = {vecs[c].exp_busy, vecs[c].exp_done, vecs[c].exp_valid,
             vecs[c].exp_last, vecs[c].exp_data};
      check($sformatf("vec_c%0d", c), act, exp);
      tick();
    end
    start = 1'b0;

    // Consumer stalled for 20 cycles: only DEPTH reads may be outstanding.
    start   = 1'b1;
    m_ready = 1'b0;
    tick();
    start    = 1'b0;
    unstable = 0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (c >= 4 && (m_valid !== 1'b1 || m_data !== 64'h1000)) unstable++;
      tick();
    end
    check("stall_addr",     rns_rd_addr,      4'h3);
    check("stall_count",    dut.u_fifo.count, 3'd4);
    check("stall_data",     m_data,           64'h1000);
    check("stall_unstable", unstable,         0);
    run_stream("after_stall", 1'b0, 0);

    run_stream("toggle",    1'b1, 2);
    run_stream("restart",   1'b1, 1);
    run_stream("last_hold", 1'b1, 3);

    // Reset in mid-stream at cycle 8 for 2 cycles.
    start   = 1'b1;
    m_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("pre_rst_valid", m_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  busy,        1'b0);
    check("midrst_done",  done,        1'b0);
    check("midrst_valid", m_valid,     1'b0);
    check("midrst_last",  m_last,      1'b0);
    check("midrst_data",  m_data,      64'h0);
    check("midrst_addr",  rns_rd_addr, 4'h0);
    bad = 0;
    repeat (2) begin
      tick();
      if (m_valid || done || busy) bad++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      if (m_valid || done || busy) bad++;
    end
    check("midrst_quiet", bad, 0);
    run_stream("post_rst", 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
